pipe_delay: RTL and testbench

PIPE_DELAY -- requirements
Module: pipe_delay

---
 rtl/pipe_delay_if.sv | 25 ++
 rtl/pipe_delay.sv | 72 +++++++
 tb/tb_pipe_delay.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_delay_if.sv
// Handshake bundle for pipe_delay: stream-in controls and tapped outputs.
interface pipe_delay_if #(
  parameter int WIDTH = 8,
  parameter int TAPW  = 2
);
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [TAPW-1:0]  tap;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [TAPW:0]    occ;
  logic             changed;

  modport master (
    output en, flush, in_valid, in_data, tap,
    input  out_data, out_valid, occ, changed
  );

  modport slave (
    input  en, flush, in_valid, in_data, tap,
    output out_data, out_valid, occ, changed
  );
endinterface

// File: rtl/pipe_delay.sv
// Stallable, flushable delay line with a clamped output tap, occupancy count
// and a registered "selected output changed" flag.
module pipe_delay #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter int               TAPW    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         reset,
  pipe_delay_if.slave bus
);
  localparam int OW = TAPW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0]            vld_pipe;
  logic [WIDTH-1:0]            sel_data;
  logic [WIDTH-1:0]            prev_data;
  logic                        sel_vld;
  logic                        chg;
  logic [OW-1:0]               cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg      <= {DEPTH{RST_VAL}};
      vld_pipe <= '0;
    end else if (bus.flush) begin
      stg      <= {DEPTH{RST_VAL}};
      vld_pipe <= '0;
    end else if (bus.en) begin
      stg[0]      <= bus.in_data;
      vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i]      <= stg[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Out-of-range taps fall through to the last stage (clamp, no wrap).
  always_comb begin
    sel_data = stg[DEPTH-1];
    sel_vld  = vld_pipe[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(bus.tap) == i) begin
        sel_data = stg[i];
        sel_vld  = vld_pipe[i];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + OW'(vld_pipe[i]);
  end

  // Tracks the selected word, so a tap switch alone can raise the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_data <= RST_VAL;
      chg       <= 1'b0;
    end else begin
      prev_data <= sel_data;
      chg       <= (sel_data != prev_data);
    end
  end

  assign bus.out_data  = sel_data;
  assign bus.out_valid = sel_vld;
  assign bus.occ       = cnt;
  assign bus.changed   = chg;
endmodule

// File: tb/tb_pipe_delay.sv
// Drives a DEPTH=4 and a DEPTH=3 pipe with identical stimulus and checks both
// against a word-history model, plus table vectors and corner sequences.
module tb_pipe_delay;
  localparam logic [7:0] RV4 = 8'h00;
  localparam logic [7:0] RV3 = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_delay_if #(.WIDTH(8), .TAPW(2)) b4 ();
  pipe_delay_if #(.WIDTH(8), .TAPW(2)) b3 ();

  pipe_delay #(.WIDTH(8), .DEPTH(4), .TAPW(2), .RST_VAL(RV4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));
  pipe_delay #(.WIDTH(8), .DEPTH(3), .TAPW(2), .RST_VAL(RV3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic [7:0] d;
    logic       v;
  } word_t;

  typedef struct {
    logic       e, f, iv;
    logic [7:0] d;
    logic [1:0] tp;
    logic [7:0] xd;
    logic       xv;
    logic [2:0] xo;
  } vec_t;

  // Most recent accepted word first; entry i is what sits in stage i.
  word_t      hist[$];
  logic [7:0] prev4, prev3;
  logic       ch4, ch3;
  logic [1:0] cur_tap;
  int         n_run, n_fail;

  function automatic int clamp(int depth, int tp);
    return (tp < depth) ? tp : depth - 1;
  endfunction

  function automatic logic [7:0] m_data(int depth, logic [7:0] rv, int tp);
    int te = clamp(depth, tp);
    return (te < hist.size()) ? hist[te].d : rv;
  endfunction

  function automatic logic m_vld(int depth, int tp);
    int te = clamp(depth, tp);
    return (te < hist.size()) ? hist[te].v : 1'b0;
  endfunction

  function automatic int m_occ(int depth);
    int c = 0;
    for (int i = 0; i < hist.size() && i < depth; i++) if (hist[i].v) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("d4_data", b4.out_data, m_data(4, RV4, cur_tap));
    chk("d4_vld", b4.out_valid, m_vld(4, cur_tap));
    chk("d4_occ", b4.occ, m_occ(4));
    chk("d4_chg", b4.changed, ch4);
    chk("d3_data", b3.out_data, m_data(3, RV3, cur_tap));
    chk("d3_vld", b3.out_valid, m_vld(3, cur_tap));
    chk("d3_occ", b3.occ, m_occ(3));
    chk("d3_chg", b3.changed, ch3);
  endtask

  task automatic set_in(input logic e, f, iv, input logic [7:0] d, input logic [1:0] tp);
    b4.en = e; b4.flush = f; b4.in_valid = iv; b4.in_data = d; b4.tap = tp;
    b3.en = e; b3.flush = f; b3.in_valid = iv; b3.in_data = d; b3.tap = tp;
    cur_tap = tp;
  endtask

  task automatic step(input logic e, f, iv, input logic [7:0] d, input logic [1:0] tp);
    logic [7:0] pre4, pre3;
    word_t w;
    set_in(e, f, iv, d, tp);
    pre4 = m_data(4, RV4, tp);
    pre3 = m_data(3, RV3, tp);
    @(posedge clk);
    ch4 = (pre4 != prev4); prev4 = pre4;
    ch3 = (pre3 != prev3); prev3 = pre3;
    if (f) hist.delete();
    else if (e) begin
      w.d = d; w.v = iv;
      hist.push_front(w);
      if (hist.size() > 4) void'(hist.pop_back());
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic retap(input logic [1:0] tp);
    b4.tap = tp; b3.tap = tp; cur_tap = tp;
    #1;
    check_all();
  endtask

  // Asserted and released between edges while the clock is low.
  task automatic do_reset();
    #1 reset = 1'b1;
    hist.delete();
    prev4 = RV4; prev3 = RV3; ch4 = 1'b0; ch3 = 1'b0;
    #1 check_all();
    chk("rst_vld4", b4.out_valid, 0);
    chk("rst_occ4", b4.occ, 0);
    #1 reset = 1'b0;
  endtask

  vec_t tbl[7];
  logic [2:0] alt_occ[4];
  logic       alt_vld[4];

  initial begin
    n_run = 0; n_fail = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 2'd3, 8'h00, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 2'd3, 8'h00, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd3, 8'h00, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 8'h11, 1'b1, 3'd4};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h55, 2'd3, 8'h22, 1'b1, 3'd4};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h66, 2'd3, 8'h33, 1'b1, 3'd4};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h77, 2'd3, 8'h44, 1'b1, 3'd4};
    alt_occ = '{3'd1, 3'd1, 3'd2, 3'd2};
    alt_vld = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    hist.delete();
    prev4 = RV4; prev3 = RV3; ch4 = 1'b0; ch3 = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_out4", b4.out_data, RV4);
    chk("rst_out3", b3.out_data, RV3);
    reset = 1'b0;

    // Straight stream through tap 3
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].tp);
      chk("tbl_data", b4.out_data, tbl[i].xd);
      chk("tbl_vld", b4.out_valid, tbl[i].xv);
      chk("tbl_occ", b4.occ, tbl[i].xo);
    end

    // Stall after the second word: 0x11 emerges after the fourth enabled edge
    do_reset();
    step(1, 0, 1, 8'h11, 3);
    step(1, 0, 1, 8'h22, 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'hEE, 3);
      chk("stall_occ", b4.occ, 2);
      chk("stall_vld", b4.out_valid, 0);
    end
    step(1, 0, 1, 8'h33, 3);
    chk("stall_pre", b4.out_valid, 0);
    step(1, 0, 1, 8'h44, 3);
    chk("stall_out1", b4.out_data, 8'h11);
    step(1, 0, 1, 8'h55, 3);
    chk("stall_out2", b4.out_data, 8'h22);

    // Flush a full pipe while offering 0xAA
    chk("full_occ", b4.occ, 4);
    step(1, 1, 1, 8'hAA, 3);
    chk("flush_occ", b4.occ, 0);
    for (int t = 0; t < 4; t++) begin
      retap(2'(t));
      chk("flush_d4", b4.out_data, RV4);
      chk("flush_d3", b3.out_data, RV3);
      chk("flush_v4", b4.out_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00, 3);
      chk("no_AA", b4.out_data == 8'hAA, 0);
    end

    // Tap clamp on DEPTH=3 and same-cycle tap switch
    do_reset();
    step(1, 0, 1, 8'h01, 3);
    step(1, 0, 1, 8'h02, 3);
    step(1, 0, 1, 8'h03, 3);
    chk("clamp_d3", b3.out_data, 8'h01);
    chk("clamp_v3", b3.out_valid, 1);
    retap(0);
    chk("retap_d3", b3.out_data, 8'h03);
    step(0, 0, 0, 8'h00, 0);
    chk("retap_chg", b3.changed, 1);

    // Mid-stream async reset with occ=3, then clean restart
    do_reset();
    step(1, 0, 1, 8'hC1, 2);
    step(1, 0, 1, 8'hC2, 2);
    step(1, 0, 1, 8'hC3, 2);
    chk("pre_rst_occ", b4.occ, 3);
    do_reset();
    chk("mid_rst_d4", b4.out_data, RV4);
    step(1, 0, 1, 8'hD1, 0);
    chk("restart_d4", b4.out_data, 8'hD1);

    // Alternating valid at tap 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, alt_vld[i], 8'(8'h10 * (i + 1)), 0);
      chk("alt_occ", b4.occ, alt_occ[i]);
      chk("alt_vld", b4.out_valid, alt_vld[i]);
    end

    // Random traffic against the history model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) retap(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
